// File: rtl/controle_disparo_if.sv
// controle_disparo_if: map, shot command and game status bundle between the shot controller and its neighbours.
interface controle_disparo_if;
  logic [6:0] mapa0, mapa1, mapa2, mapa3, mapa4;
  logic [2:0] linha, coluna;
  logic       disparar, iniciar;
  logic [6:0] acerto0, acerto1, acerto2, acerto3, acerto4;
  logic [6:0] jogado0, jogado1, jogado2, jogado3, jogado4;
  logic [5:0] restantes;
  logic [4:0] tentativas;
  logic [2:0] resultado;
  logic       jogando, vitoria, derrota;
  modport master (
    output mapa0, mapa1, mapa2, mapa3, mapa4, linha, coluna, disparar, iniciar,
    input  acerto0, acerto1, acerto2, acerto3, acerto4,
    input  jogado0, jogado1, jogado2, jogado3, jogado4,
    input  restantes, tentativas, resultado, jogando, vitoria, derrota
  );
  modport slave (
    input  mapa0, mapa1, mapa2, mapa3, mapa4, linha, coluna, disparar, iniciar,
    output acerto0, acerto1, acerto2, acerto3, acerto4,
    output jogado0, jogado1, jogado2, jogado3, jogado4,
    output restantes, tentativas, resultado, jogando, vitoria, derrota
  );
endinterface

// File: rtl/controle_disparo.sv
// controle_disparo: battleship shot controller; LIMITE_TENTATIVAS_EN enables the attempt limit and defeat.
module controle_disparo #(
  parameter int MAX_TENTATIVAS = 20
) (
  input logic clk,
  input logic reset,
  controle_disparo_if.slave bus
);
`ifdef LIMITE_TENTATIVAS_EN
  localparam bit LIMITE = 1'b1;
`else
  localparam bit LIMITE = 1'b0;
`endif
  localparam logic [4:0] CARGA = 5'(MAX_TENTATIVAS) & {5{LIMITE}};
  typedef enum logic [2:0] {OCIOSO, CARREGAR, JOGANDO, AVALIAR, VITORIA, DERROTA} estado_t;
  estado_t estado;
  logic [34:0] snap, acr, jog, mapa, sel;
  logic [2:0] l_q, c_q, res;
  logic [5:0] rest, rest_n, pop, pos;
  logic [4:0] tent, tent_n;
  logic disp_q, ini_q, disp_ed, ini_ed, valido, rep, navio, novo;
  assign mapa = {bus.mapa0, bus.mapa1, bus.mapa2, bus.mapa3, bus.mapa4};
  assign disp_ed = bus.disparar & ~disp_q;
  assign ini_ed = bus.iniciar & ~ini_q;
  always_comb begin
    pop = '0;
    for (int i = 0; i < 35; i++) pop = pop + 6'(mapa[i]);
  end
  // row 0 sits in the top bits and column c maps to bit 6-c of its row
  assign valido = (l_q <= 3'd4) && (c_q <= 3'd6);
  assign pos = 6'd34 - (6'(l_q) * 6'd7 + 6'(c_q));
  assign sel = valido ? 35'd1 << pos : '0;
  assign rep = |(jog & sel);
  assign navio = |(snap & sel);
  assign novo = valido && !rep;
  assign rest_n = rest - 6'(novo && navio);
  assign tent_n = tent - 5'(LIMITE && novo && tent != 5'd0);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado <= OCIOSO;
      snap <= '0;
      acr <= '0;
      jog <= '0;
      rest <= '0;
      tent <= '0;
      res <= '0;
      l_q <= '0;
      c_q <= '0;
      disp_q <= 1'b0;
      ini_q <= 1'b0;
    end else begin
      disp_q <= bus.disparar;
      ini_q <= bus.iniciar;
      case (estado)
        OCIOSO, VITORIA, DERROTA: if (ini_ed) estado <= CARREGAR;
        CARREGAR: begin
          snap <= mapa;
          acr <= '0;
          jog <= '0;
          rest <= pop;
          tent <= CARGA;
          res <= 3'b000;
          estado <= pop == 6'd0 ? VITORIA : JOGANDO;
        end
        JOGANDO: if (disp_ed) begin
          l_q <= bus.linha;
          c_q <= bus.coluna;
          estado <= AVALIAR;
        end
        AVALIAR: begin
          acr <= acr | (snap & sel);
          jog <= jog | sel;
          rest <= rest_n;
          tent <= tent_n;
          res <= !valido ? 3'b100 : rep ? 3'b011 : navio ? 3'b010 : 3'b001;
          estado <= rest_n == 6'd0 ? VITORIA : (LIMITE && tent_n == 5'd0) ? DERROTA : JOGANDO;
        end
        default: estado <= OCIOSO;
      endcase
    end
  end
  assign {bus.acerto0, bus.acerto1, bus.acerto2, bus.acerto3, bus.acerto4} = acr;
  assign {bus.jogado0, bus.jogado1, bus.jogado2, bus.jogado3, bus.jogado4} = jog;
  assign bus.restantes = rest;
  assign bus.tentativas = tent;
  assign bus.resultado = res;
  assign bus.jogando = estado == JOGANDO || estado == AVALIAR;
  assign bus.vitoria = estado == VITORIA;
  assign bus.derrota = estado == DERROTA;
endmodule

// File: tb/tb_controle_disparo.sv
// tb_controle_disparo: directed shot table plus corner sequences on a 20-attempt and a 3-attempt controller.
module tb_controle_disparo;
`ifdef LIMITE_TENTATIVAS_EN
  localparam bit LIM = 1'b1;
`else
  localparam bit LIM = 1'b0;
`endif
  logic clk = 1'b0, reset;
  always #5 clk = ~clk;
  controle_disparo_if b ();
  controle_disparo_if b3 ();
  controle_disparo #(.MAX_TENTATIVAS(20)) u1 (.clk(clk), .reset(reset), .bus(b));
  controle_disparo #(.MAX_TENTATIVAS(3)) u3 (.clk(clk), .reset(reset), .bus(b3));
  assign b3.mapa0 = b.mapa0;
  assign b3.mapa1 = b.mapa1;
  assign b3.mapa2 = b.mapa2;
  assign b3.mapa3 = b.mapa3;
  assign b3.mapa4 = b.mapa4;
  assign b3.linha = b.linha;
  assign b3.coluna = b.coluna;
  assign b3.disparar = b.disparar;
  assign b3.iniciar = b.iniciar;
  typedef struct {
    logic [2:0] l, c, res;
    logic [5:0] rest;
    int used;
  } vec_t;
  vec_t v[17];
  int n_chk = 0, n_fail = 0;
  logic [34:0] m_acr, m_jog, bit_sel;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", n, a, e);
    end
  endtask
  task automatic set_mapa(input logic [6:0] r0, r1, r2, r3, r4);
    {b.mapa0, b.mapa1, b.mapa2, b.mapa3, b.mapa4} = {r0, r1, r2, r3, r4};
  endtask
  task automatic pulse_ini();
    @(negedge clk) b.iniciar = 1'b1;
    @(negedge clk) b.iniciar = 1'b0;
    @(negedge clk);
  endtask
  task automatic shoot(input logic [2:0] l, c);
    @(negedge clk);
    b.linha = l;
    b.coluna = c;
    b.disparar = 1'b1;
    @(negedge clk) b.disparar = 1'b0;
    @(negedge clk);
  endtask
  initial begin
    v[0]  = '{3'd0, 3'd4, 3'd2, 6'd12, 1};
    v[1]  = '{3'd0, 3'd4, 3'd3, 6'd12, 1};
    v[2]  = '{3'd0, 3'd0, 3'd1, 6'd12, 2};
    v[3]  = '{3'd5, 3'd2, 3'd4, 6'd12, 2};
    v[4]  = '{3'd1, 3'd7, 3'd4, 6'd12, 2};
    v[5]  = '{3'd1, 3'd3, 3'd2, 6'd11, 3};
    v[6]  = '{3'd1, 3'd4, 3'd2, 6'd10, 4};
    v[7]  = '{3'd2, 3'd0, 3'd2, 6'd9, 5};
    v[8]  = '{3'd2, 3'd4, 3'd2, 6'd8, 6};
    v[9]  = '{3'd2, 3'd6, 3'd2, 6'd7, 7};
    v[10] = '{3'd3, 3'd0, 3'd2, 6'd6, 8};
    v[11] = '{3'd3, 3'd1, 3'd2, 6'd5, 9};
    v[12] = '{3'd3, 3'd2, 3'd2, 6'd4, 10};
    v[13] = '{3'd3, 3'd6, 3'd2, 6'd3, 11};
    v[14] = '{3'd4, 3'd0, 3'd2, 6'd2, 12};
    v[15] = '{3'd4, 3'd5, 3'd2, 6'd1, 13};
    v[16] = '{3'd4, 3'd6, 3'd2, 6'd0, 14};
    reset = 1'b1;
    b.linha = '0;
    b.coluna = '0;
    b.disparar = 1'b0;
    b.iniciar = 1'b0;
    set_mapa(7'b0000100, 7'b0001100, 7'b1000101, 7'b1110001, 7'b1000011);
    repeat (2) @(negedge clk);
    chk("reset_acerto", {b.acerto0, b.acerto1, b.acerto2, b.acerto3, b.acerto4}, 0);
    chk("reset_jogado", {b.jogado0, b.jogado1, b.jogado2, b.jogado3, b.jogado4}, 0);
    chk("reset_restantes", b.restantes, 0);
    chk("reset_tentativas", b.tentativas, 0);
    chk("reset_resultado", b.resultado, 0);
    chk("reset_flags", {b.jogando, b.vitoria, b.derrota}, 0);
    reset = 1'b0;
    pulse_ini();
    chk("load_restantes", b.restantes, 13);
    chk("load_tentativas", b.tentativas, LIM ? 20 : 0);
    chk("load_jogando", b.jogando, 1);
    chk("load_masks", {b.acerto0, b.acerto1, b.acerto2, b.acerto3, b.acerto4, b.jogado0, b.jogado1, b.jogado2, b.jogado3, b.jogado4}, 0);
    chk("load_tent3", b3.tentativas, LIM ? 3 : 0);
    m_acr = '0;
    m_jog = '0;
    for (int i = 0; i < 17; i++) begin
      shoot(v[i].l, v[i].c);
      bit_sel = 35'd1 << (34 - (int'(v[i].l) * 7 + int'(v[i].c)));
      if (v[i].res == 3'd2) m_acr = m_acr | bit_sel;
      if (v[i].res == 3'd2 || v[i].res == 3'd1) m_jog = m_jog | bit_sel;
      chk($sformatf("v%0d_resultado", i), b.resultado, v[i].res);
      chk($sformatf("v%0d_restantes", i), b.restantes, v[i].rest);
      chk($sformatf("v%0d_tentativas", i), b.tentativas, LIM ? 20 - v[i].used : 0);
      chk($sformatf("v%0d_acerto", i), {b.acerto0, b.acerto1, b.acerto2, b.acerto3, b.acerto4}, m_acr);
      chk($sformatf("v%0d_jogado", i), {b.jogado0, b.jogado1, b.jogado2, b.jogado3, b.jogado4}, m_jog);
      chk($sformatf("v%0d_flags", i), {b.jogando, b.vitoria, b.derrota}, v[i].rest != 0 ? 3'b100 : 3'b010);
      chk($sformatf("v%0d_tent3", i), b3.tentativas, LIM ? (v[i].used >= 3 ? 0 : 3 - v[i].used) : 0);
      chk($sformatf("v%0d_derrota3", i), b3.derrota, LIM && v[i].used >= 3);
      if (i == 0) chk("first_hit_rows", {b.acerto0, b.jogado0}, {7'b0000100, 7'b0000100});
      if (i == 2) begin
        chk("water_rows", {b.acerto0, b.jogado0}, {7'b0000100, 7'b1000100});
        pulse_ini();
        chk("ini_ignored_rest", b.restantes, 12);
        chk("ini_ignored_jog", b.jogado0, 7'b1000100);
      end
    end
    chk("vit3", b3.vitoria, !LIM);
    shoot(3'd0, 3'd0);
    chk("post_vit_resultado", b.resultado, 2);
    chk("post_vit_jogado", {b.jogado0, b.jogado1, b.jogado2, b.jogado3, b.jogado4}, m_jog);
    chk("post_vit_flag", b.vitoria, 1);
    pulse_ini();
    chk("reload_restantes", b.restantes, 13);
    chk("reload_tentativas", b.tentativas, LIM ? 20 : 0);
    chk("reload_masks", {b.acerto0, b.acerto1, b.acerto2, b.acerto3, b.acerto4, b.jogado0, b.jogado1, b.jogado2, b.jogado3, b.jogado4}, 0);
    chk("reload_resultado", b.resultado, 0);
    chk("reload_flags", {b.jogando, b.vitoria, b.derrota}, 3'b100);
    set_mapa(7'd0, 7'd0, 7'd0, 7'd0, 7'd0);
    shoot(3'd0, 3'd4);
    chk("snapshot_resultado", b.resultado, 2);
    chk("snapshot_restantes", b.restantes, 12);
    @(negedge clk);
    b.linha = 3'd1;
    b.coluna = 3'd3;
    b.disparar = 1'b1;
    @(negedge clk);
    b.disparar = 1'b0;
    reset = 1'b1;
    #1;
    chk("abort_masks", {b.acerto0, b.acerto1, b.acerto2, b.acerto3, b.acerto4, b.jogado0, b.jogado1, b.jogado2, b.jogado3, b.jogado4}, 0);
    chk("abort_counters", {b.restantes, b.tentativas, b.resultado}, 0);
    chk("abort_flags", {b.jogando, b.vitoria, b.derrota, b3.jogando}, 0);
    @(negedge clk) reset = 1'b0;
    pulse_ini();
    chk("empty_flags", {b.jogando, b.vitoria, b.derrota}, 3'b010);
    chk("empty_restantes", b.restantes, 0);
    chk("empty_vit3", b3.vitoria, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/controle_disparo.md
# controle_disparo

Shot controller for the battleship game, directly downstream of the map selector. On `iniciar` it snapshots the confirmed 5×7 ship map (`mapa0`..`mapa4`). It then evaluates player shots (row/column plus `disparar`) against that snapshot and keeps the hit mask and shot mask for the display stage. It also tracks remaining ship cells and remaining attempts, and flags victory or defeat.

## Interface
- `MAX_TENTATIVAS`, default 20: attempts granted per game (1..31).
- `clk`  in  1  system clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `mapa0`..`mapa4`  in  7 each  confirmed ship map rows from the map selector; 1 = ship cell.
- `linha`  in  3  target row, valid 0..4.
- `coluna`  in  3  target column, valid 0..6; column c ↔ row bit (6−c).
- `disparar`  in  1  fire button, already debounced and synchronous to `clk`.
- `iniciar`  in  1  start/restart button, already debounced and synchronous to `clk`.
- `acerto0`..`acerto4`  out  7 each  hit mask (ship cells already hit).
- `jogado0`..`jogado4`  out  7 each  shot mask (all cells already fired on).
- `restantes`  out  6  ship cells not yet hit.
- `tentativas`  out  5  attempts left.
- `resultado`  out  3  last shot outcome:
  - 000 none
  - 001 water
  - 010 hit
  - 011 repeated
  - 100 invalid
- `jogando`, `vitoria`, `derrota`  out  1 each  state flags.

## Operation
- States:
  - OCIOSO: after reset.
  - CARREGAR
  - JOGANDO
  - AVALIAR
  - VITORIA
  - DERROTA
- Edge detection: `disparar` and `iniciar` act only on a rising edge (1 now, 0 at the previous clock). Holding a button does nothing further.
- `iniciar` edge in OCIOSO, VITORIA or DERROTA → CARREGAR. In CARREGAR:
  - copy `mapa*` into internal snapshot;
  - clear hit and shot masks;
  - `restantes` = popcount of 35 map bits;
  - `tentativas` = `MAX_TENTATIVAS`;
  - `resultado` = 000.
  - Next state is JOGANDO, or VITORIA if popcount = 0.
- `iniciar` in JOGANDO or AVALIAR is ignored; so is `disparar` outside JOGANDO.
- `disparar` edge in JOGANDO: latch `linha`/`coluna`, go to AVALIAR. AVALIAR evaluates once, in priority order:
  - `linha` > 4 or `coluna` > 6 → invalid; nothing else changes.
  - Cell already in shot mask → repeated; nothing else changes.
  - Ship cell → hit; set hit and shot bits; `restantes` −1; `tentativas` −1.
  - Otherwise → water; set shot bit; `tentativas` −1.
- After AVALIAR:
  - if `restantes` = 0, go to VITORIA (takes priority, including on the last attempt);
  - else if `tentativas` = 0, go to DERROTA;
  - else return to JOGANDO.
- Changes to `mapa*` after CARREGAR have no effect until the next `iniciar`.
- Flags: `jogando` = 1 in JOGANDO/AVALIAR; `vitoria` = 1 only in VITORIA; `derrota` = 1 only in DERROTA.
- Masks and counters hold their final values in VITORIA/DERROTA until the next `iniciar`.

## Timing
- Reset values:
  - all masks 0;
  - `restantes` 0;
  - `tentativas` 0;
  - `resultado` 000;
  - all flags 0;
  - state OCIOSO;
  - edge-detect history 0.
- Reset asserted mid-game aborts immediately to the reset values.
- `iniciar` edge sampled at edge k → CARREGAR at k. Snapshot, counters and masks are valid after edge k+1. `jogando` = 1 after k+1.
- `disparar` edge sampled at edge k → AVALIAR at k. Masks, counters and `resultado` update at edge k+1. Terminal flag or JOGANDO follows from edge k+1.
- Next shot is accepted from edge k+2. A `disparar` edge arriving during AVALIAR is dropped, not queued.
- `disparar` and `iniciar` rising together in JOGANDO: shot processed, `iniciar` ignored.
- Popcount is purely combinational in CARREGAR, max 35 (fits 6 bits). Counters never underflow.

## Configuration
- `LIMITE_TENTATIVAS_EN` defined: attempt limit as described; DERROTA reachable.
- Not defined:
  - unlimited attempts;
  - `tentativas` held at 0;
  - no decrement;
  - DERROTA and `derrota` never reached;
  - `MAX_TENTATIVAS` unused.

## Test plan
- Reset, then `iniciar` with map rows 0000100/0001100/1000101/1110001/1000011 → two cycles later `restantes`=13, `tentativas`=20, `jogando`=1, masks 0.
- Fire (0,4) → `resultado`=010, `acerto0`=`jogado0`=0000100, `restantes`=12, `tentativas`=19; fire (0,4) again → 011, counters unchanged.
- Fire (0,0) → 001, `jogado0`=1000100, `acerto0` unchanged, `tentativas` −1; fire (5,2) and (1,7) → 100 each, nothing else changes.
- Hit all 13 ship cells with no misses → `vitoria`=1, `restantes`=0, `tentativas`=7; further `disparar` ignored; `iniciar` reloads.
- With `LIMITE_TENTATIVAS_EN`, `MAX_TENTATIVAS`=3, three water shots → `derrota`=1 after third; same without macro → still `jogando`, `tentativas`=0.
- All-zero map then `iniciar` → VITORIA directly. Reset asserted during AVALIAR → all outputs at reset values on that cycle.
